// File: rtl/lsu_pkg.sv
// ============================================================================
// Module  : lsu_pkg
// Brief   : Size encodings, lane helpers and FIFO entry widths for the LSU.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    localparam int SIZE_W = 2;
    localparam int OFF_W  = 2;

    function automatic logic misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] be_gen(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_rep(input size_e sz, input logic [31:0] wd);
        case (sz)
            SZ_B:    return {4{wd[7:0]}};
            SZ_H:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input size_e sz, input logic sext,
                                                 input logic [1:0] off, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{off, 3'b000} +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (sz)
            SZ_B:    return {{24{sext & b[7]}}, b};
            SZ_H:    return {{16{sext & h[15]}}, h};
            default: return rd;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_obi_master_if.sv
// ============================================================================
// Module  : lsu_obi_master_if
// Brief   : RI5CY-style data bus (req/gnt/rvalid) between LSU and memory.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_obi_master_if;
    logic        data_req_o;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i
    );
endinterface

`default_nettype wire

// File: rtl/lsu_txn_fifo.sv
// ============================================================================
// Module  : lsu_txn_fifo
// Brief   : In-order FIFO of granted-but-unanswered bus transactions.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_txn_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] data_o,
    output logic      [CNT_W-1:0] count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_push, w_pop;

    // Explicit wrap so non-trivial depths and DEPTH=1 share one pointer scheme.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign w_push  = push_i && (!full_o || pop_i);
    assign w_pop   = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (w_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/lsu_obi_master.sv
// ============================================================================
// Module  : lsu_obi_master
// Brief   : Load/store unit driving a req/gnt/rvalid data bus with in-order tracking.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_obi_master
    import lsu_pkg::*;
#(
    parameter int OUTSTANDING_MAX = 2,
    parameter int TAG_W           = 5
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             lsu_valid_i,
    output logic                  lsu_ready_o,
    input  wire logic             lsu_we_i,
    input  wire logic [1:0]       lsu_size_i,
    input  wire logic             lsu_sext_i,
    input  wire logic [31:0]      lsu_addr_i,
    input  wire logic [31:0]      lsu_wdata_i,
    input  wire logic [TAG_W-1:0] lsu_tag_i,
    output logic                  lsu_rvalid_o,
    output logic                  lsu_rwe_o,
    output logic      [31:0]      lsu_rdata_o,
    output logic      [TAG_W-1:0] lsu_rtag_o,
    output logic                  lsu_err_o,
    output logic      [TAG_W-1:0] lsu_err_tag_o,
    output logic                  lsu_proto_err_o,
    lsu_obi_master_if.master      bus
);

    localparam int CNT_W = $clog2(OUTSTANDING_MAX + 1);
    localparam logic [CNT_W:0] C_MAX = (CNT_W + 1)'(OUTSTANDING_MAX);

    typedef struct packed {
        logic              we;
        logic [SIZE_W-1:0] size;
        logic              sext;
        logic [OFF_W-1:0]  off;
        logic [TAG_W-1:0]  tag;
    } ent_t;

    logic              req_q, req_d;
    logic [29:0]       addr_q;
    logic              we_q, sext_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [SIZE_W-1:0] size_q;
    logic [OFF_W-1:0]  off_q;
    logic [TAG_W-1:0]  tag_q;

    logic              rvalid_q, rwe_q, err_q, proto_q;
    logic [31:0]       rdata_q;
    logic [TAG_W-1:0]  rtag_q, err_tag_q;

    size_e             w_size;
    logic              w_mis, w_accept, w_issue, w_push, w_pop, w_proto;
    logic [CNT_W-1:0]  w_cnt;
    logic [CNT_W:0]    w_inflight;
    logic              w_full, w_empty;
    ent_t              w_push_ent, w_head;

    assign w_size     = size_e'(lsu_size_i);
    assign w_mis      = misaligned(w_size, lsu_addr_i[1:0]);
    assign w_inflight = {1'b0, w_cnt} + {{CNT_W{1'b0}}, req_q};
    // A pop in this cycle is deliberately not credited, keeping ready off the rvalid path.
    assign lsu_ready_o = (!req_q || bus.data_gnt_i) && !w_full && (w_inflight < C_MAX);
    assign w_accept   = lsu_valid_i && lsu_ready_o;
    assign w_issue    = w_accept && !w_mis;
    assign w_push     = req_q && bus.data_gnt_i;
    assign w_pop      = bus.data_rvalid_i && !w_empty;
    assign w_proto    = bus.data_rvalid_i && w_empty;
    assign req_d      = w_issue ? 1'b1 : (w_push ? 1'b0 : req_q);

    assign w_push_ent = '{we: we_q, size: size_q, sext: sext_q, off: off_q, tag: tag_q};

    lsu_txn_fifo #(
        .DEPTH (OUTSTANDING_MAX),
        .WIDTH ($bits(ent_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .data_i  (w_push_ent),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .count_o (w_cnt),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q     <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            sext_q    <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            off_q     <= '0;
            tag_q     <= '0;
            rvalid_q  <= 1'b0;
            rwe_q     <= 1'b0;
            rdata_q   <= '0;
            rtag_q    <= '0;
            err_q     <= 1'b0;
            err_tag_q <= '0;
            proto_q   <= 1'b0;
        end else begin
            req_q <= req_d;
            if (w_issue) begin
                addr_q  <= lsu_addr_i[31:2];
                we_q    <= lsu_we_i;
                sext_q  <= lsu_sext_i;
                be_q    <= be_gen(w_size, lsu_addr_i[1:0]);
                wdata_q <= wdata_rep(w_size, lsu_wdata_i);
                size_q  <= lsu_size_i;
                off_q   <= lsu_addr_i[1:0];
                tag_q   <= lsu_tag_i;
            end

            err_q <= w_accept && w_mis;
            if (w_accept && w_mis) err_tag_q <= lsu_tag_i;

            rvalid_q <= w_pop;
            if (w_pop) begin
                rwe_q   <= w_head.we;
                rtag_q  <= w_head.tag;
                rdata_q <= w_head.we ? 32'h0
                         : load_extract(size_e'(w_head.size), w_head.sext, w_head.off, bus.data_rdata_i);
            end

            if (w_proto) proto_q <= 1'b1;
        end
    end

    assign bus.data_req_o   = req_q;
    assign bus.data_addr_o  = {addr_q, 2'b00};
    assign bus.data_we_o    = we_q;
    assign bus.data_be_o    = be_q;
    assign bus.data_wdata_o = wdata_q;

    assign lsu_rvalid_o    = rvalid_q;
    assign lsu_rwe_o       = rwe_q;
    assign lsu_rdata_o     = rdata_q;
    assign lsu_rtag_o      = rtag_q;
    assign lsu_err_o       = err_q;
    assign lsu_err_tag_o   = err_tag_q;
    assign lsu_proto_err_o = proto_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_obi_master.sv
// ============================================================================
// Module  : tb_lsu_obi_master
// Brief   : Scoreboard bench for lsu_obi_master with a random memory responder.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_obi_master;

    localparam int MAXO = 2;
    localparam int TW   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid = 1'b0, we = 1'b0, sext = 1'b0;
    logic [1:0]    size = 2'b00;
    logic [31:0]   addr = '0, wdata = '0;
    logic [TW-1:0] tag = '0;

    logic          lsu_ready_o, lsu_rvalid_o, lsu_rwe_o, lsu_err_o, lsu_proto_err_o;
    logic [31:0]   lsu_rdata_o;
    logic [TW-1:0] lsu_rtag_o, lsu_err_tag_o;

    lsu_obi_master_if bus ();

    lsu_obi_master #(.OUTSTANDING_MAX(MAXO), .TAG_W(TW)) dut (
        .clk             (clk),
        .rst             (rst),
        .lsu_valid_i     (valid),
        .lsu_ready_o     (lsu_ready_o),
        .lsu_we_i        (we),
        .lsu_size_i      (size),
        .lsu_sext_i      (sext),
        .lsu_addr_i      (addr),
        .lsu_wdata_i     (wdata),
        .lsu_tag_i       (tag),
        .lsu_rvalid_o    (lsu_rvalid_o),
        .lsu_rwe_o       (lsu_rwe_o),
        .lsu_rdata_o     (lsu_rdata_o),
        .lsu_rtag_o      (lsu_rtag_o),
        .lsu_err_o       (lsu_err_o),
        .lsu_err_tag_o   (lsu_err_tag_o),
        .lsu_proto_err_o (lsu_proto_err_o),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    typedef struct { bit we; bit [1:0] sz; bit sx; int off; logic [TW-1:0] tag; } cmd_t;
    typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wd; logic we; } req_t;

    cmd_t          cmd_q [$];
    req_t          breq_q [$];
    logic [TW-1:0] err_q [$];
    logic [31:0]   rsp_q [$];
    logic [31:0]   forced_q [$];

    int pass_cnt = 0, total_cnt = 0;
    int gnt_mode = 2, rv_budget = -1, pending_rsp = 0;
    bit inj_proto = 1'b0;
    int m_out = 0, m_pend = 0;
    bit m_proto = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Reference rules written in byte-lane arithmetic.
    function automatic bit legal(input bit [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b0;
        return (a % (32'd1 << sz)) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input bit [1:0] sz, input int off);
        logic [3:0] be = '0;
        int n = 1 << sz;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] exp_wd(input bit [1:0] sz, input logic [31:0] wd);
        logic [31:0] r = '0;
        int n = 1 << sz;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input bit [1:0] sz, input bit sx, input int off,
                                             input logic [31:0] rd);
        int bits = 8 << sz;
        logic [31:0] v;
        if (sz == 2'd2) return rd;
        v = rd >> (8 * off);
        v = v & ((32'd1 << bits) - 32'd1);
        if (sx && v[bits-1]) v = v - (32'd1 << bits);
        return v;
    endfunction

    // Memory responder
    always @(posedge clk) begin
        #1;
        if (rst) begin
            bus.data_gnt_i    = 1'b0;
            bus.data_rvalid_i = 1'b0;
            bus.data_rdata_i  = '0;
            pending_rsp       = 0;
        end else begin
            case (gnt_mode)
                0:       bus.data_gnt_i = 1'b0;
                1:       bus.data_gnt_i = 1'b1;
                default: bus.data_gnt_i = ($urandom_range(0, 2) != 0);
            endcase
            bus.data_rvalid_i = 1'b0;
            if (inj_proto) begin
                bus.data_rvalid_i = 1'b1;
                bus.data_rdata_i  = $urandom;
                inj_proto         = 1'b0;
            end else if (pending_rsp > 0 && rv_budget != 0 && $urandom_range(0, 2) != 0) begin
                bus.data_rvalid_i = 1'b1;
                bus.data_rdata_i  = (forced_q.size() > 0) ? forced_q.pop_front() : $urandom;
                rsp_q.push_back(bus.data_rdata_i);
                pending_rsp--;
                if (rv_budget > 0) rv_budget--;
            end
        end
    end

    // Model bookkeeping and scoreboard monitor
    logic        s_stall = 1'b0, s_we;
    logic [31:0] s_addr, s_wd;
    logic [3:0]  s_be;

    always @(negedge clk) begin
        bit   ready_exp;
        cmd_t c;
        req_t r;
        logic [31:0] rd;
        if (rst) begin
            m_out = 0; m_pend = 0; m_proto = 1'b0; s_stall = 1'b0;
        end else begin
            ready_exp = (m_pend == 0 || bus.data_gnt_i) && (m_out < MAXO);
            chk("ready", lsu_ready_o, ready_exp);
            chk("req", bus.data_req_o, m_pend != 0);
            chk("proto_err", lsu_proto_err_o, m_proto);
            if (s_stall) begin
                chk("stable_addr", bus.data_addr_o, s_addr);
                chk("stable_be", bus.data_be_o, s_be);
                chk("stable_wdata", bus.data_wdata_o, s_wd);
                chk("stable_we", bus.data_we_o, s_we);
            end
            if (m_pend != 0 && bus.data_gnt_i) begin
                if (breq_q.size() == 0) chk("grant_unexpected", bus.data_req_o, 1'b0);
                else begin
                    r = breq_q.pop_front();
                    chk("bus_addr", bus.data_addr_o, r.addr);
                    chk("bus_be", bus.data_be_o, r.be);
                    chk("bus_wdata", bus.data_wdata_o, r.wd);
                    chk("bus_we", bus.data_we_o, r.we);
                end
                pending_rsp++;
            end
            s_stall = (m_pend != 0) && !bus.data_gnt_i;
            s_addr = bus.data_addr_o; s_be = bus.data_be_o;
            s_wd = bus.data_wdata_o; s_we = bus.data_we_o;

            if (lsu_rvalid_o) begin
                if (cmd_q.size() == 0 || rsp_q.size() == 0) chk("rvalid_unexpected", lsu_rvalid_o, 1'b0);
                else begin
                    c  = cmd_q.pop_front();
                    rd = rsp_q.pop_front();
                    chk("rwe", lsu_rwe_o, c.we);
                    chk("rtag", lsu_rtag_o, c.tag);
                    chk("rdata", lsu_rdata_o, c.we ? 32'h0 : exp_load(c.sz, c.sx, c.off, rd));
                end
            end
            if (lsu_err_o) begin
                if (err_q.size() == 0) chk("err_unexpected", lsu_err_o, 1'b0);
                else chk("err_tag", lsu_err_tag_o, err_q.pop_front());
            end

            if (bus.data_rvalid_i) begin
                if (m_out - m_pend > 0) m_out--;
                else m_proto = 1'b1;
            end
            if (m_pend != 0 && bus.data_gnt_i) m_pend--;
            if (valid && ready_exp && legal(size, addr)) begin
                m_out++; m_pend++;
            end
        end
    end

    task automatic issue(input bit w, input bit [1:0] sz, input bit sx, input logic [31:0] a,
                         input logic [31:0] wd, input logic [TW-1:0] tg);
        bit done = 1'b0;
        @(posedge clk); #1;
        valid = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd; tag = tg;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (lsu_ready_o) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("accept_timeout", done, 1'b1);
        if (done) begin
            if (!legal(sz, a)) err_q.push_back(tg);
            else begin
                cmd_q.push_back('{we: w, sz: sz, sx: sx, off: int'(a[1:0]), tag: tg});
                breq_q.push_back('{addr: {a[31:2], 2'b00}, be: exp_be(sz, int'(a[1:0])),
                                   wd: w ? exp_wd(sz, wd) : wd & 32'h0 | exp_wd(sz, wd), we: w});
            end
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic drain();
        bool_loop: begin
            int i;
            for (i = 0; i < 2000; i++) begin
                @(negedge clk);
                if (cmd_q.size() == 0 && err_q.size() == 0 && m_out == 0) break;
            end
            chk("drain_timeout", (i < 2000), 1'b1);
        end
    endtask

    initial begin
        bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0; bus.data_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", bus.data_req_o, 1'b0);
        chk("rst_addr", bus.data_addr_o, 32'h0);
        chk("rst_be_wd", {bus.data_be_o, bus.data_wdata_o[27:0]}, 32'h0);
        chk("rst_out", {lsu_rvalid_o, lsu_rwe_o, lsu_err_o, lsu_proto_err_o, lsu_rtag_o, lsu_err_tag_o}, 32'h0);
        chk("rst_rdata", lsu_rdata_o, 32'h0);
        rst = 1'b0;

        // Store byte with lane replication
        gnt_mode = 2;
        issue(1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_00A5, 5'd1);
        idle(); drain();
        // Half / byte loads with fixed response words
        forced_q.push_back(32'h8001_7FFF);
        issue(1'b0, 2'd1, 1'b1, 32'h0000_0022, 32'h0, 5'd2); idle(); drain();
        forced_q.push_back(32'h8001_7FFF);
        issue(1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'h0, 5'd3); idle(); drain();
        forced_q.push_back(32'h8001_7FFF);
        issue(1'b0, 2'd0, 1'b1, 32'h0000_0021, 32'h0, 5'd4); idle(); drain();
        // Misaligned word
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 5'd9); idle(); drain();

        // Outstanding limit with responses withheld
        gnt_mode = 1; rv_budget = 0;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 5'd3);
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0, 5'd4);
        fork
            issue(1'b0, 2'd2, 1'b0, 32'h0000_0108, 32'h0, 5'd5);
            begin repeat (6) @(posedge clk); rv_budget = 1; end
        join
        idle(); rv_budget = -1; drain();

        // Random traffic
        gnt_mode = 2;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a = $urandom;
            bit [1:0] sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 1);
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, TW'($urandom));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle(); drain();

        // Grant stall then protocol error
        gnt_mode = 0;
        issue(1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 5'd7);
        fork
            issue(1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'h0, 5'd8);
            begin repeat (6) @(posedge clk); gnt_mode = 1; end
        join
        idle(); drain();
        @(negedge clk); inj_proto = 1'b1;
        repeat (4) @(negedge clk);
        chk("proto_sticky", lsu_proto_err_o, 1'b1);

        // Asynchronous reset with two in flight
        rv_budget = 0;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, 5'd10);
        issue(1'b0, 2'd2, 1'b0, 32'h0000_0204, 32'h0, 5'd11);
        idle();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_req", bus.data_req_o, 1'b0);
        chk("arst_out", {lsu_rvalid_o, lsu_err_o, lsu_proto_err_o, bus.data_be_o}, 32'h0);
        cmd_q.delete(); breq_q.delete(); err_q.delete(); rsp_q.delete(); forced_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rv_budget = -1; gnt_mode = 2;
        @(negedge clk);
        chk("post_rst_ready", lsu_ready_o, 1'b1);
        issue(1'b0, 2'd0, 1'b1, 32'h0000_0301, 32'h0, 5'd12);
        idle(); drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/lsu_obi_master.md
Name: lsu_obi_master

Overview:
Core-side load/store unit that drives the RI5CY-style data bus (req/gnt/rvalid) toward the data-memory BFM.
- Accepts one load/store command per cycle from the execute stage.
- Performs alignment checks, byte-enable generation and store-data replication.
- Tracks granted-but-unanswered transactions in an in-order FIFO.
- Returns sign/zero-extended load data, or a store completion, to writeback together with the command's tag.

Parameters:
OUTSTANDING_MAX, 2, max transactions counted as in flight (pending request plus granted-but-unanswered); power of two, 1..8
TAG_W, 5, width of the writeback tag (destination register index)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
lsu_valid_i  in  1  core command valid
lsu_ready_o  out  1  command accepted when valid&&ready
lsu_we_i  in  1  1=store, 0=load
lsu_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
lsu_sext_i  in  1  sign-extend load result
lsu_addr_i  in  32  byte address
lsu_wdata_i  in  32  store data, right-aligned
lsu_tag_i  in  TAG_W  tag returned with completion
lsu_rvalid_o  out  1  completion pulse
lsu_rwe_o  out  1  completion belongs to a store
lsu_rdata_o  out  32  extended load data (0 for stores)
lsu_rtag_o  out  TAG_W  tag of completion
lsu_err_o  out  1  misaligned/illegal-size pulse, no bus traffic
lsu_err_tag_o  out  TAG_W  tag of faulting command
lsu_proto_err_o  out  1  sticky: rvalid received with empty FIFO
data_req_o  out  1  bus request
data_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
data_we_o  out  1  write enable
data_be_o  out  4  byte enables
data_wdata_o  out  32  replicated store data
data_gnt_i  in  1  grant
data_rvalid_i  in  1  response valid (in order)
data_rdata_i  in  32  response data (word)

Behaviour:
- Reset: every output 0, FIFO empty, in-flight count 0. Reset mid-operation discards all in-flight state.
- cnt: granted-but-unanswered entries. pend = data_req_o.
- lsu_ready_o = (!pend || data_gnt_i) && (cnt + pend < OUTSTANDING_MAX). This is conservative; a same-cycle pop is not credited.
- Accept and check: misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Faulting command: next cycle lsu_err_o=1 for one cycle with lsu_err_tag_o; no request, no FIFO entry.
- Issue: accepting a legal command registers the bus fields; data_req_o=1 from the next cycle. The bus fields stay stable while req=1 && !gnt.
- Byte enables: byte → be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}. Half → be = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}. Word → be = 1111, wdata as-is.
- Grant: req && gnt pushes {we, size, sext, addr[1:0], tag} into the FIFO.
  - data_req_o drops next cycle unless a new command is accepted in the same cycle, in which case it stays high with the new fields (back-to-back issue).
- Response: data_rvalid_i pops the FIFO head. The next cycle gives lsu_rvalid_o=1 with rtag and rwe.
  - Load: shift rdata right by 8*addr[1:0], then take the low byte or half, sign- or zero-extend per sext (word passes through).
  - Store: rdata_o = 0.
  - Latency is 1 cycle from rvalid.
- Simultaneous push and pop: cnt unchanged; FIFO pointers wrap modulo OUTSTANDING_MAX.
- Protocol error: rvalid with cnt==0 sets lsu_proto_err_o, which stays set until reset. The response is ignored and no completion is produced.
- lsu_err_o and lsu_rvalid_o may assert in the same cycle; they are independent.

Decomposition:
- Package lsu_pkg: size encodings (SZ_B, SZ_H, SZ_W), be_gen and load_extract functions, FIFO entry field widths.
- One sub-module, lsu_txn_fifo: parameterised in-order FIFO with push, pop, count, full and empty.
- Request register and response formatting stay in the top module.

Test Plan:
1. Store byte addr=0x00000013, wdata=0x000000A5 → data_addr_o=0x00000010, be=1000, wdata=0xA5A5A5A5; rvalid → lsu_rvalid_o=1, rwe=1, rdata=0.
2. Load half sext=1 addr=0x00000022, rdata_i=0x8001_7FFF → lsu_rdata_o=0xFFFF8001. Same with sext=0 → 0x00008001. Byte at addr 0x21 with sext=1 → 0x0000007F.
3. Word load addr=0x00000006 → lsu_err_o pulse with tag; data_req_o never asserts; cnt stays 0.
4. Back-to-back loads tags 3, 4, 5 with gnt held high and rvalid withheld → lsu_ready_o drops after 2 in flight. After one rvalid, tag 3 completes first and the third request issues.
5. data_gnt_i held low 5 cycles → data_addr_o, data_be_o and data_wdata_o stay stable; no accept. rvalid injected with empty FIFO → lsu_proto_err_o=1 and stays set.
6. Assert rst with 2 in flight → all outputs 0 asynchronously; after release lsu_ready_o=1 and cnt=0.
